oqpsk_chip_scheduler: RTL and testbench

OQPSK_CHIP_SCHEDULER -- requirements
Module: oqpsk_chip_scheduler

---
 rtl/oqpsk_chip_scheduler_if.sv | 50 +++++
 rtl/oqpsk_chip_scheduler.sv | 112 +++++++++++
 tb/tb_oqpsk_chip_scheduler.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/oqpsk_chip_scheduler_if.sv
// Purpose : Bundles the FIFO-side and chip-output signals of the O-QPSK chip scheduler.
// Ports   : master = scheduler side (reads FIFO flags/data, drives pops and chip stream);
//           slave  = environment side (drives FIFO flags/data and enable, observes outputs).
interface oqpsk_chip_scheduler_if;
  logic i_enable;
  logic i_I_fifo_empty;
  logic i_Q_fifo_empty;
  logic i_I_data;
  logic i_Q_data;
  logic o_I_read;
  logic o_Q_read;
  logic o_serial_chip;
  logic o_serial_chip_valid;
  logic o_symbol_start;
  logic o_symbol_end;
  logic o_underflow;
  logic o_busy;

  modport master (
    input  i_enable,
    input  i_I_fifo_empty,
    input  i_Q_fifo_empty,
    input  i_I_data,
    input  i_Q_data,
    output o_I_read,
    output o_Q_read,
    output o_serial_chip,
    output o_serial_chip_valid,
    output o_symbol_start,
    output o_symbol_end,
    output o_underflow,
    output o_busy
  );

  modport slave (
    output i_enable,
    output i_I_fifo_empty,
    output i_Q_fifo_empty,
    output i_I_data,
    output i_Q_data,
    input  o_I_read,
    input  o_Q_read,
    input  o_serial_chip,
    input  o_serial_chip_valid,
    input  o_symbol_start,
    input  o_symbol_end,
    input  o_underflow,
    input  o_busy
  );
endinterface

// File: rtl/oqpsk_chip_scheduler.sv
// Purpose : Interleaves chips from I and Q FWFT FIFOs into one serial stream (I0,Q0,I1,Q1,...),
//           framing symbols of CHIPS_PER_SYMBOL chips and aborting a symbol after TIMEOUT empty cycles.
// Latency : chip, valid and framing pulses appear one cycle after the combinational pop.
// Backpr. : an empty FIFO stalls the current phase; i_enable only takes effect at symbol boundaries.
// Ports   : i_clk, i_rst (async, active-high) plus the master modport of oqpsk_chip_scheduler_if.
module oqpsk_chip_scheduler #(
  parameter int CHIPS_PER_SYMBOL = 32,
  parameter int TIMEOUT          = 15
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  oqpsk_chip_scheduler_if.master        bus
);
  localparam int            CW         = $clog2(CHIPS_PER_SYMBOL);
  localparam logic [CW-1:0] LAST_CHIP  = CW'(CHIPS_PER_SYMBOL - 1);
  localparam logic [7:0]    WAIT_LIMIT = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, I_PHASE, Q_PHASE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [7:0]    wait_q,  wait_d;
  logic          chip_q,  chip_d;
  logic          vld_q,   vld_d;
  logic          sos_q,   sos_d;
  logic          eos_q,   eos_d;
  logic          unf_q,   unf_d;
  logic          pop_i,   pop_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    chip_d  = chip_q;
    vld_d   = 1'b0;
    sos_d   = 1'b0;
    eos_d   = 1'b0;
    unf_d   = 1'b0;
    pop_i   = 1'b0;
    pop_q   = 1'b0;
    case (state_q)
      IDLE: begin
        // Counters are forced to zero here so any restart begins a fresh symbol.
        cnt_d  = '0;
        wait_d = '0;
        if (bus.i_enable && !bus.i_I_fifo_empty) begin
          state_d = I_PHASE;
        end
      end
      I_PHASE, Q_PHASE: begin
        pop_i = (state_q == I_PHASE) && !bus.i_I_fifo_empty;
        pop_q = (state_q == Q_PHASE) && !bus.i_Q_fifo_empty;
        // A pop always wins over a timeout; the two can only meet on the same cycle in principle.
        if (pop_i || pop_q) begin
          chip_d = pop_i ? bus.i_I_data : bus.i_Q_data;
          vld_d  = 1'b1;
          sos_d  = (cnt_q == '0);
          eos_d  = (cnt_q == LAST_CHIP);
          wait_d = '0;
          if (cnt_q == LAST_CHIP) begin
            // Even chip count: the last chip is always a Q chip, next symbol restarts on I.
            cnt_d   = '0;
            state_d = bus.i_enable ? I_PHASE : IDLE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = pop_i ? Q_PHASE : I_PHASE;
          end
        end else if (wait_q == WAIT_LIMIT) begin
          // Waiting at a symbol boundary (count 0) loses no data, so it drops to IDLE silently.
          unf_d   = (cnt_q != '0);
          cnt_d   = '0;
          wait_d  = '0;
          state_d = IDLE;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wait_q  <= '0;
      chip_q  <= 1'b0;
      vld_q   <= 1'b0;
      sos_q   <= 1'b0;
      eos_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      chip_q  <= chip_d;
      vld_q   <= vld_d;
      sos_q   <= sos_d;
      eos_q   <= eos_d;
      unf_q   <= unf_d;
    end
  end

  assign bus.o_I_read            = pop_i & ~i_rst;
  assign bus.o_Q_read            = pop_q & ~i_rst;
  assign bus.o_serial_chip       = chip_q;
  assign bus.o_serial_chip_valid = vld_q;
  assign bus.o_symbol_start      = sos_q;
  assign bus.o_symbol_end        = eos_q;
  assign bus.o_underflow         = unf_q;
  assign bus.o_busy              = (state_q != IDLE);
endmodule

// File: tb/tb_oqpsk_chip_scheduler.sv
// Purpose : Self-checking bench for oqpsk_chip_scheduler: queue-based FIFO models feed the DUT,
//           a chip-index reference model predicts pops, chips, framing, underflow and busy.
module tb_oqpsk_chip_scheduler;
  localparam int CPS = 32;
  localparam int TO  = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  oqpsk_chip_scheduler_if bus();

  oqpsk_chip_scheduler #(.CHIPS_PER_SYMBOL(CPS), .TIMEOUT(TO)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Environment
  bit iq[$];
  bit qq[$];
  bit en, hold_i, hold_q;

  // Reference model: a symbol is a run of CPS chips; even chip index needs I, odd needs Q.
  bit m_active;
  int m_idx, m_wait;
  bit p_i, p_q, ia, qa;
  bit e_vld, e_sos, e_eos, e_unf, e_chip;

  // Observed DUT event counts for scenario-level checks
  int o_vld, o_sos, o_eos, o_unf;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_inputs();
    bus.i_enable       = en;
    bus.i_I_fifo_empty = hold_i || (iq.size() == 0);
    bus.i_Q_fifo_empty = hold_q || (qq.size() == 0);
    bus.i_I_data       = (iq.size() > 0) ? iq[0] : 1'($urandom);
    bus.i_Q_data       = (qq.size() > 0) ? qq[0] : 1'($urandom);
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_idx    = 0;
    m_wait   = 0;
  endtask

  task automatic clr_obs();
    o_vld = 0; o_sos = 0; o_eos = 0; o_unf = 0;
  endtask

  // One clock cycle: drive, check combinational pops, clock, advance model, check registered outputs.
  task automatic step();
    @(negedge clk);
    drive_inputs();
    #1;
    ia  = !hold_i && (iq.size() > 0);
    qa  = !hold_q && (qq.size() > 0);
    p_i = m_active && (m_idx % 2 == 0) && ia;
    p_q = m_active && (m_idx % 2 == 1) && qa;
    check_eq("I_read", 32'(bus.o_I_read), 32'(p_i));
    check_eq("Q_read", 32'(bus.o_Q_read), 32'(p_q));
    @(posedge clk);
    e_vld = 1'b0; e_sos = 1'b0; e_eos = 1'b0; e_unf = 1'b0; e_chip = 1'b0;
    if (!m_active) begin
      m_idx  = 0;
      m_wait = 0;
      if (en && ia) m_active = 1'b1;
    end else if (p_i || p_q) begin
      e_vld  = 1'b1;
      e_chip = p_i ? iq.pop_front() : qq.pop_front();
      e_sos  = (m_idx == 0);
      e_eos  = (m_idx == CPS - 1);
      m_wait = 0;
      m_idx++;
      if (m_idx == CPS) begin
        m_idx    = 0;
        m_active = en;
      end
    end else begin
      m_wait++;
      if (m_wait == TO) begin
        e_unf = (m_idx != 0);
        model_reset();
      end
    end
    #1;
    check_eq("valid",     32'(bus.o_serial_chip_valid), 32'(e_vld));
    check_eq("sym_start", 32'(bus.o_symbol_start),      32'(e_sos));
    check_eq("sym_end",   32'(bus.o_symbol_end),        32'(e_eos));
    check_eq("underflow", 32'(bus.o_underflow),         32'(e_unf));
    check_eq("busy",      32'(bus.o_busy),              32'(m_active));
    if (e_vld) check_eq("chip", 32'(bus.o_serial_chip), 32'(e_chip));
    o_vld += int'(bus.o_serial_chip_valid);
    o_sos += int'(bus.o_symbol_start);
    o_eos += int'(bus.o_symbol_end);
    o_unf += int'(bus.o_underflow);
  endtask

  // Assert reset mid-cycle (away from any edge) and require all outputs low at once.
  task automatic async_reset_check(input string tag);
    #2 rst = 1'b1;
    #1;
    check_eq({tag, "_valid"}, 32'(bus.o_serial_chip_valid), 32'd0);
    check_eq({tag, "_chip"},  32'(bus.o_serial_chip),       32'd0);
    check_eq({tag, "_sos"},   32'(bus.o_symbol_start),      32'd0);
    check_eq({tag, "_eos"},   32'(bus.o_symbol_end),        32'd0);
    check_eq({tag, "_unf"},   32'(bus.o_underflow),         32'd0);
    check_eq({tag, "_busy"},  32'(bus.o_busy),              32'd0);
    check_eq({tag, "_rdI"},   32'(bus.o_I_read),            32'd0);
    check_eq({tag, "_rdQ"},   32'(bus.o_Q_read),            32'd0);
    model_reset();
    @(posedge clk);
    #1;
    check_eq({tag, "_busy_hold"}, 32'(bus.o_busy), 32'd0);
    rst = 1'b0;
  endtask

  task automatic fill(input int ni, input int nq);
    for (int k = 0; k < ni; k++) iq.push_back(1'($urandom));
    for (int k = 0; k < nq; k++) qq.push_back(1'($urandom));
  endtask

  // Empty the FIFOs and let the DUT return to IDLE through timeouts.
  task automatic settle();
    en = 1'b0; hold_i = 1'b0; hold_q = 1'b0;
    iq.delete(); qq.delete();
    for (int k = 0; k < 2 * TO + 4; k++) step();
  endtask

  int stall_left;
  int c;
  int burst_left;
  int burst_sel;

  initial begin
    rst = 1'b1; en = 1'b0; hold_i = 1'b0; hold_q = 1'b0;
    model_reset();
    clr_obs();
    drive_inputs();
    #3;
    check_eq("rst_valid", 32'(bus.o_serial_chip_valid), 32'd0);
    check_eq("rst_busy",  32'(bus.o_busy),              32'd0);
    check_eq("rst_unf",   32'(bus.o_underflow),         32'd0);
    check_eq("rst_rdI",   32'(bus.o_I_read),            32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Full FIFOs but disabled: nothing moves.
    fill(16, 16);
    clr_obs();
    for (int k = 0; k < 30; k++) step();
    check_eq("dis_vld_cnt", 32'(o_vld), 32'd0);
    check_eq("dis_fifo_I",  32'(iq.size()), 32'd16);

    // Back-to-back symbol from preloaded FIFOs.
    en = 1'b1;
    clr_obs();
    for (int k = 0; k < 40; k++) step();
    check_eq("b2b_vld_cnt", 32'(o_vld), 32'd32);
    check_eq("b2b_sos_cnt", 32'(o_sos), 32'd1);
    check_eq("b2b_eos_cnt", 32'(o_eos), 32'd1);
    settle();

    // Short Q stall after chip 7: gap but no underflow.
    fill(16, 16); en = 1'b1; stall_left = 5;
    clr_obs();
    for (int k = 0; k < 70; k++) begin
      hold_q = 1'b0;
      if (m_idx == 7 && stall_left > 0) begin hold_q = 1'b1; stall_left--; end
      step();
    end
    check_eq("stall_vld_cnt", 32'(o_vld), 32'd32);
    check_eq("stall_eos_cnt", 32'(o_eos), 32'd1);
    check_eq("stall_unf_cnt", 32'(o_unf), 32'd0);
    settle();

    // Long Q stall at chip 11: underflow, then a fresh full symbol.
    fill(22, 21); en = 1'b1; stall_left = 15;
    clr_obs();
    for (int k = 0; k < 90; k++) begin
      hold_q = 1'b0;
      if (m_idx == 11 && stall_left > 0) begin hold_q = 1'b1; stall_left--; end
      step();
    end
    check_eq("uf_unf_cnt", 32'(o_unf), 32'd1);
    check_eq("uf_eos_cnt", 32'(o_eos), 32'd1);
    check_eq("uf_sos_cnt", 32'(o_sos), 32'd2);
    check_eq("uf_vld_cnt", 32'(o_vld), 32'd43);
    settle();

    // Enable dropped at chip 10: symbol completes, then idle.
    fill(20, 20); en = 1'b1;
    clr_obs();
    for (int k = 0; k < 60; k++) begin
      if (m_idx == 10) en = 1'b0;
      step();
    end
    check_eq("den_vld_cnt", 32'(o_vld), 32'd32);
    check_eq("den_eos_cnt", 32'(o_eos), 32'd1);
    check_eq("den_fifo_I",  32'(iq.size()), 32'd4);
    settle();

    // Reset at chip 20, then restart from a fresh symbol.
    fill(30, 30); en = 1'b1;
    c = 0;
    while (m_idx != 20 && c < 100) begin step(); c++; end
    check_eq("reach_chip20", 32'(m_idx), 32'd20);
    async_reset_check("midrst");
    clr_obs();
    for (int k = 0; k < 30; k++) step();
    check_eq("midrst_sos_cnt", 32'(o_sos), 32'd1);
    settle();

    // Randomized traffic, stalls, enable toggling and occasional resets.
    burst_left = 0; burst_sel = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 1) == 0 && iq.size() < 8) iq.push_back(1'($urandom));
      if ($urandom_range(0, 1) == 0 && qq.size() < 8) qq.push_back(1'($urandom));
      en = ($urandom_range(0, 15) != 0);
      if (burst_left > 0) burst_left--;
      else if ($urandom_range(0, 149) == 0) begin
        burst_left = $urandom_range(10, 25);
        burst_sel  = $urandom_range(0, 1);
      end
      hold_i = (burst_left > 0 && burst_sel == 0) || ($urandom_range(0, 9) == 0);
      hold_q = (burst_left > 0 && burst_sel == 1) || ($urandom_range(0, 9) == 0);
      step();
      if ($urandom_range(0, 599) == 0) async_reset_check("rndrst");
    end
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
